systolic_mac_pe: RTL and testbench
==================================

# systolic_mac_pe

Parametrised processing element for the systolic matrix-multiply array, the next generation of the single-MAC cell. Operands flow east (A) and south (B) through registered pass-throughs. Products accumulate in a wide accumulator under valid-qualified handshakes, and per-tile results are retired on a `last` marker. Finished results leave through a vertical drain shift chain shared with the rest of the column.

## Interface
Parameters:
- `DATA_WIDTH`, 16, operand width.
- `ACC_WIDTH`, 40, accumulator/result width; must be ≥ 2·DATA_WIDTH.
- `SIGNED`, 1, 1 = two's-complement operands, 0 = unsigned.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `a_in` in DATA_WIDTH, `a_vld_in` in 1, `last_in` in 1: A operand from the west; `last_in` marks the final pair of a tile.
- `b_in` in DATA_WIDTH, `b_vld_in` in 1: B operand from the north.
- `a_out` out DATA_WIDTH, `a_vld_out` out 1, `last_out` out 1: registered A forwarding east.
- `b_out` out DATA_WIDTH, `b_vld_out` out 1: registered B forwarding south.
- `drain` in 1: result-chain shift enable, common to the column.
- `c_in` in ACC_WIDTH, `c_vld_in` in 1: drain chain from the north neighbour (tied 0 at the top row).
- `c_out` out ACC_WIDTH, `c_vld_out` out 1: drain chain to the south.
- `busy` out 1: tile open or product in flight.
- `err` out 1: sticky protocol error.

## Operation
- Fire condition: `a_vld_in && b_vld_in`. Zero-valued operands are legal and accumulate normally; qualification is by valid only.
- Exactly one of the two valids high: no fire, operands still forwarded, `err` set.
- Product: full 2·DATA_WIDTH product, sign- or zero-extended to ACC_WIDTH according to `SIGNED`.
- Stage P registers `prod`, `p_vld`, `p_last`.
- Accumulate stage, when `p_vld`:
  - `p_last`=0: `acc <= acc + prod`.
  - `p_last`=1: `res <= acc + prod`, `res_vld <= 1`, `acc <= 0`. A new tile may start the very next cycle.
- Arithmetic wraps modulo 2^ACC_WIDTH, except when the saturation feature is compiled in (see Configuration).
- Tile state machine:
  - IDLE → ACCUM on a fire without last.
  - ACCUM → IDLE on a fire with last.
  - IDLE stays IDLE on a fire with last (single-pair tile).
  - `busy` = (state==ACCUM) | `p_vld`.
- Drain, when `drain`=1:
  - If `res_vld`: `c_out <= res`, `c_vld_out <= 1`, clear `res_vld`.
  - Otherwise: `c_out <= c_in`, `c_vld_out <= c_vld_in`.
  - When `drain`=0: `c_vld_out <= 0`, and `c_out` holds its value.
  - Holding `drain` for N cycles on an N-row column emits all results at the bottom, bottom row first.
- Retire while `res_vld`=1 and no drain that cycle: the new result overwrites the old one and `err` is set.
- Retire and drain in the same cycle: the old result drains, the new result loads, and `res_vld` stays 1 (set wins).
- Reset values: all outputs, `acc`, `res`, `res_vld`, and pipeline valids are 0; state is IDLE. Reset mid-tile discards in-flight products and the partial sum.

## Timing
- Pass-through latency is 1 cycle: inputs at edge t appear on `*_out` after edge t.
- Fire in cycle t: `prod` is valid in t+1, and the accumulator reflects it in t+2.
- Fire with `last` in cycle t: `res_vld`=1 from cycle t+2. Drain is eligible in t+2, and `c_vld_out` is valid in t+3.
- Back-to-back fires every cycle sustain full throughput.
- `err` is visible the cycle after the offending edge and clears only on `rst`.

## Configuration
- Macro: `SYSTOLIC_PE_SAT_EN`.
- Defined: the accumulate-stage sum saturates to the signed (or unsigned) ACC_WIDTH max/min, and an extra output `sat` (1 bit, sticky until the tile retires) goes high.
- Undefined: wrap-around arithmetic and no `sat` port.

## Structure
- `systolic_pkg` holds:
  - the tile state enum (IDLE, ACCUM);
  - a `PE_ACC_GUARD` constant (ACC_WIDTH − 2·DATA_WIDTH, checked ≥ 0 at elaboration);
  - saturation limit functions.
- Sub-module `pe_mult_stage`: the registered multiplier (operands in, extended product plus `p_vld`/`p_last` out), so the multiplier can be swapped for a DSP-mapped version.

## Test plan
- DATA_WIDTH=8, ACC_WIDTH=20, SIGNED=1. Pairs (3,4),(−2,5),(7,0) with last on the third → `res`=2 at t+2; `c_out`=2 one cycle after `drain`.
- Back-to-back tiles: (1,1) last, then (2,3) last in the next cycle. Drain held 2 cycles → `c_out` shows 6. The next tile's `acc` starts from 0.
- 3-PE column, each with results 10/20/30 top→bottom, drain held 3 cycles → bottom `c_out` sequence 30, 20, 10 with `c_vld_out`=1,1,1.
- `a_vld_in`=1, `b_vld_in`=0 → no accumulation, `a_out` forwarded, `err`=1 the next cycle.
- `rst` asserted with `p_vld`=1 mid-tile → all outputs 0 the next cycle. A subsequent (2,2) last gives `res`=4.
- Accumulate (127,127) 40 times with SIGNED=1, ACC_WIDTH=20. With `SYSTOLIC_PE_SAT_EN`: `res`=524287 and `sat`=1. Without it: `res` equals the sum modulo 2^20.

Source files
------------

// File: rtl/systolic_mac_pe_pkg.sv
// Shared tile-state type, width guard and saturation limits for the systolic MAC PE.
// The limit functions are consumed when SYSTOLIC_PE_SAT_EN is defined.
package systolic_pkg;
    typedef enum logic [0:0] { IDLE = 1'b0, ACCUM = 1'b1 } tile_state_e;

    localparam int PE_MAX_ACC    = 128;
    localparam int PE_DATA_WIDTH = 16;
    localparam int PE_ACC_WIDTH  = 40;
    localparam int PE_ACC_GUARD  = PE_ACC_WIDTH - 2 * PE_DATA_WIDTH;

    function automatic int pe_acc_guard(int data_w, int acc_w);
        return acc_w - 2 * data_w;
    endfunction

    // Limits are built wide and truncated to ACC_WIDTH by the caller.
    function automatic logic [PE_MAX_ACC-1:0] sat_max(int acc_w, bit sgn);
        logic [PE_MAX_ACC-1:0] one;
        one = PE_MAX_ACC'(1);
        return sgn ? (one << (acc_w - 1)) - one : (one << acc_w) - one;
    endfunction

    function automatic logic [PE_MAX_ACC-1:0] sat_min(int acc_w, bit sgn);
        logic [PE_MAX_ACC-1:0] one;
        one = PE_MAX_ACC'(1);
        return sgn ? (one << (acc_w - 1)) : '0;
    endfunction
endpackage

// File: rtl/systolic_mac_pe_if.sv
// Port bundle of one systolic MAC PE; slave is the PE side, master the driving side.
// SYSTOLIC_PE_SAT_EN adds the sticky sat flag.
interface systolic_mac_pe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
);
    logic [DATA_WIDTH-1:0] a_in, b_in, a_out, b_out;
    logic                  a_vld_in, b_vld_in, last_in;
    logic                  a_vld_out, b_vld_out, last_out;
    logic                  drain;
    logic [ACC_WIDTH-1:0]  c_in, c_out;
    logic                  c_vld_in, c_vld_out;
    logic                  busy, err;
`ifdef SYSTOLIC_PE_SAT_EN
    logic                  sat;
`endif

    modport slave (
`ifdef SYSTOLIC_PE_SAT_EN
        output sat,
`endif
        input  a_in, a_vld_in, last_in, b_in, b_vld_in, drain, c_in, c_vld_in,
        output a_out, a_vld_out, last_out, b_out, b_vld_out, c_out, c_vld_out, busy, err
    );

    modport master (
`ifdef SYSTOLIC_PE_SAT_EN
        input  sat,
`endif
        output a_in, a_vld_in, last_in, b_in, b_vld_in, drain, c_in, c_vld_in,
        input  a_out, a_vld_out, last_out, b_out, b_vld_out, c_out, c_vld_out, busy, err
    );
endinterface

// File: rtl/systolic_mac_pe_mult.sv
// Registered multiplier stage: full product extended to ACC_WIDTH plus valid/last tags.
// Kept separate so a DSP-mapped multiplier can replace it.
module pe_mult_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_fire,
    input  logic                  i_last,
    output logic [ACC_WIDTH-1:0]  o_prod,
    output logic                  o_p_vld,
    output logic                  o_p_last
);
    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0]        w_a, w_b, w_p;
    logic [ACC_WIDTH-1:0] w_prod;

    // Low PW bits of the product of PW-bit extended operands equal the exact product.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_a    = PW'($signed(i_a));
            assign w_b    = PW'($signed(i_b));
            assign w_p    = w_a * w_b;
            assign w_prod = ACC_WIDTH'($signed(w_p));
        end else begin : g_unsigned
            assign w_a    = PW'(i_a);
            assign w_b    = PW'(i_b);
            assign w_p    = w_a * w_b;
            assign w_prod = ACC_WIDTH'(w_p);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            o_prod   <= '0;
            o_p_vld  <= 1'b0;
            o_p_last <= 1'b0;
        end else begin
            o_p_vld  <= i_fire;
            o_p_last <= i_fire & i_last;
            if (i_fire) o_prod <= w_prod;
        end
    end
endmodule

// File: rtl/systolic_mac_pe.sv
// Systolic MAC PE: registered A/B forwarding, pipelined MAC with tile retire, drain chain.
// Define SYSTOLIC_PE_SAT_EN for a saturating accumulator and the sticky sat output.
module systolic_mac_pe
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int ACC_WIDTH  = PE_ACC_WIDTH,
    parameter int SIGNED     = 1
) (
    input  logic             clk,
    input  logic             rst,
    systolic_mac_pe_if.slave pe
);
    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_ACCUM = ACCUM;

    generate
        if (pe_acc_guard(DATA_WIDTH, ACC_WIDTH) < 0 || PE_ACC_GUARD < 0) begin : g_bad_width
            $error("ACC_WIDTH must be at least 2*DATA_WIDTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_a_out, r_b_out;
    logic                  r_a_vld_out, r_b_vld_out, r_last_out;
    logic [ACC_WIDTH-1:0]  r_acc, r_res, r_c_out;
    logic                  r_res_vld, r_c_vld_out, r_err;
    logic [0:0]            r_state;
    logic                  w_fire, w_half, w_p_vld, w_p_last, w_retire;
    logic [ACC_WIDTH-1:0]  w_prod, w_sum;

    assign w_fire   = pe.a_vld_in & pe.b_vld_in;
    assign w_half   = pe.a_vld_in ^ pe.b_vld_in;
    assign w_retire = w_p_vld & w_p_last;

    pe_mult_stage #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .SIGNED(SIGNED)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .i_a     (pe.a_in),
        .i_b     (pe.b_in),
        .i_fire  (w_fire),
        .i_last  (pe.last_in),
        .o_prod  (w_prod),
        .o_p_vld (w_p_vld),
        .o_p_last(w_p_last)
    );

`ifdef SYSTOLIC_PE_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH, SIGNED != 0));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH, SIGNED != 0));

    logic [ACC_WIDTH-1:0] w_wrap;
    logic                 w_ovf_hi, w_ovf_lo, r_sat, r_tile_open;

    generate
        if (SIGNED != 0) begin : g_sat_s
            assign w_wrap   = r_acc + w_prod;
            assign w_ovf_hi = ~r_acc[ACC_WIDTH-1] & ~w_prod[ACC_WIDTH-1] &  w_wrap[ACC_WIDTH-1];
            assign w_ovf_lo =  r_acc[ACC_WIDTH-1] &  w_prod[ACC_WIDTH-1] & ~w_wrap[ACC_WIDTH-1];
        end else begin : g_sat_u
            assign {w_ovf_hi, w_wrap} = {1'b0, r_acc} + {1'b0, w_prod};
            assign w_ovf_lo = 1'b0;
        end
    endgenerate

    assign w_sum  = w_ovf_hi ? ACC_MAX : (w_ovf_lo ? ACC_MIN : w_wrap);
    assign pe.sat = r_sat;

    // sat survives the retire so it can be read with the result; the next tile's first product restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat       <= 1'b0;
            r_tile_open <= 1'b0;
        end else if (w_p_vld) begin
            r_tile_open <= ~w_p_last;
            r_sat       <= (r_tile_open & r_sat) | w_ovf_hi | w_ovf_lo;
        end
    end
`else
    assign w_sum = r_acc + w_prod;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_out     <= '0;
            r_b_out     <= '0;
            r_a_vld_out <= 1'b0;
            r_b_vld_out <= 1'b0;
            r_last_out  <= 1'b0;
            r_acc       <= '0;
            r_res       <= '0;
            r_res_vld   <= 1'b0;
            r_c_out     <= '0;
            r_c_vld_out <= 1'b0;
            r_err       <= 1'b0;
            r_state     <= S_IDLE;
        end else begin
            r_a_out     <= pe.a_in;
            r_b_out     <= pe.b_in;
            r_a_vld_out <= pe.a_vld_in;
            r_b_vld_out <= pe.b_vld_in;
            r_last_out  <= pe.last_in;

            if (w_fire) r_state <= pe.last_in ? S_IDLE : S_ACCUM;

            if (w_p_vld) begin
                if (w_p_last) begin
                    r_res <= w_sum;
                    r_acc <= '0;
                end else begin
                    r_acc <= w_sum;
                end
            end

            // A local result takes the chain slot; otherwise pass the north neighbour through.
            if (pe.drain) begin
                if (r_res_vld) begin
                    r_c_out     <= r_res;
                    r_c_vld_out <= 1'b1;
                end else begin
                    r_c_out     <= pe.c_in;
                    r_c_vld_out <= pe.c_vld_in;
                end
            end else begin
                r_c_vld_out <= 1'b0;
            end

            r_res_vld <= w_retire | (r_res_vld & ~pe.drain);
            r_err     <= r_err | w_half | (w_retire & r_res_vld & ~pe.drain);
        end
    end

    assign pe.a_out     = r_a_out;
    assign pe.b_out     = r_b_out;
    assign pe.a_vld_out = r_a_vld_out;
    assign pe.b_vld_out = r_b_vld_out;
    assign pe.last_out  = r_last_out;
    assign pe.c_out     = r_c_out;
    assign pe.c_vld_out = r_c_vld_out;
    assign pe.err       = r_err;
    assign pe.busy      = (r_state == S_ACCUM) | w_p_vld;
endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe (DATA_WIDTH=8, ACC_WIDTH=20, SIGNED=1): directed tile scenarios,
// a 3-PE drain column, and random tiles checked against a signed sum-of-products model.
module tb_systolic_mac_pe;
    localparam int DW = 8;
    localparam int AW = 20;

    typedef struct { int a; int b; logic v; logic l; } stim_t;

    logic clk = 1'b0;
    logic rst;
    logic col_drain;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [AW-1:0] got_c[$];
    logic          got_v[$];

    systolic_mac_pe_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) pe ();
    systolic_mac_pe_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) cp0 ();
    systolic_mac_pe_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) cp1 ();
    systolic_mac_pe_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) cp2 ();

    systolic_mac_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(1)) dut (.clk(clk), .rst(rst), .pe(pe));
    systolic_mac_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(1)) u_c0 (.clk(clk), .rst(rst), .pe(cp0));
    systolic_mac_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(1)) u_c1 (.clk(clk), .rst(rst), .pe(cp1));
    systolic_mac_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(1)) u_c2 (.clk(clk), .rst(rst), .pe(cp2));

    assign cp0.drain    = col_drain;
    assign cp1.drain    = col_drain;
    assign cp2.drain    = col_drain;
    assign cp1.c_in     = cp0.c_out;
    assign cp1.c_vld_in = cp0.c_vld_out;
    assign cp2.c_in     = cp1.c_out;
    assign cp2.c_vld_in = cp1.c_vld_out;

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic col_idle();
        cp0.a_vld_in = 0; cp0.b_vld_in = 0; cp0.last_in = 0;
        cp1.a_vld_in = 0; cp1.b_vld_in = 0; cp1.last_in = 0;
        cp2.a_vld_in = 0; cp2.b_vld_in = 0; cp2.last_in = 0;
    endtask

    task automatic drive(input int a, input int b, input logic av, input logic bv, input logic l);
        @(negedge clk);
        pe.a_in = DW'(a); pe.b_in = DW'(b);
        pe.a_vld_in = av; pe.b_vld_in = bv; pe.last_in = l;
    endtask

    task automatic idle();
        drive(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Holds drain for n cycles starting at the next negedge; records the chain output per cycle.
    task automatic drain_n(input bit col, input int n);
        got_c.delete(); got_v.delete();
        @(negedge clk);
        pe.a_vld_in = 0; pe.b_vld_in = 0; pe.last_in = 0;
        col_idle();
        if (col) col_drain = 1'b1; else pe.drain = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (col) begin got_c.push_back(cp2.c_out); got_v.push_back(cp2.c_vld_out); end
            else     begin got_c.push_back(pe.c_out);  got_v.push_back(pe.c_vld_out);  end
        end
        col_drain = 1'b0;
        pe.drain  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pe.a_out, pe.b_out, pe.a_vld_out, pe.b_vld_out, pe.last_out, pe.c_out, pe.c_vld_out,
             pe.busy, pe.err} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got a=%0h b=%0h c=%0h cv=%0b busy=%0b err=%0b, expected all 0",
                     pe.a_out, pe.b_out, pe.c_out, pe.c_vld_out, pe.busy, pe.err);
        end
        n_checks++;
        if ({cp2.c_out, cp2.c_vld_out, cp2.err} !== '0) begin
            n_errors++;
            $display("FAIL reset_column: got c=%0h cv=%0b err=%0b, expected 0", cp2.c_out, cp2.c_vld_out, cp2.err);
        end
`ifdef SYSTOLIC_PE_SAT_EN
        n_checks++;
        if (pe.sat !== 1'b0) begin n_errors++; $display("FAIL reset_sat: got %0b expected 0", pe.sat); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        drive(3, 4, 1, 1, 0);
        drive(-2, 5, 1, 1, 0);
        n_checks++;
        if (pe.busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy_accum: got %0b expected 1", pe.busy); end
        drive(7, 0, 1, 1, 1);
        idle();
        drain_n(0, 1);
        n_checks++;
        if (got_c[0] !== AW'(2) || got_v[0] !== 1'b1) begin
            n_errors++; $display("FAIL basic_result: got %0d vld %0b expected 2 vld 1", got_c[0], got_v[0]);
        end
        idle();
        n_checks++;
        if (pe.c_vld_out !== 1'b0 || pe.c_out !== AW'(2) || pe.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_hold: got c=%0d cv=%0b busy=%0b expected c=2 cv=0 busy=0",
                     pe.c_out, pe.c_vld_out, pe.busy);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 1, 1, 1);
        drive(2, 3, 1, 1, 1);
        drain_n(0, 2);
        n_checks++;
        if (got_c[0] !== AW'(1) || got_v[0] !== 1'b1) begin
            n_errors++; $display("FAIL b2b_first: got %0d vld %0b expected 1 vld 1", got_c[0], got_v[0]);
        end
        n_checks++;
        if (got_c[1] !== AW'(6) || got_v[1] !== 1'b1) begin
            n_errors++; $display("FAIL b2b_second: got %0d vld %0b expected 6 vld 1", got_c[1], got_v[1]);
        end
        n_checks++;
        if (pe.err !== 1'b0) begin n_errors++; $display("FAIL b2b_err: got %0b expected 0", pe.err); end
        drive(5, 5, 1, 1, 1);
        idle();
        drain_n(0, 1);
        n_checks++;
        if (got_c[0] !== AW'(25)) begin n_errors++; $display("FAIL b2b_fresh_acc: got %0d expected 25", got_c[0]); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            stim_t q[$];
            stim_t prev;
            stim_t s;
            longint sum = 0;
            int n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    s.a = $urandom_range(0, 255); s.b = $urandom_range(0, 255); s.v = 0; s.l = 0;
                    q.push_back(s);
                end
                s.a = $urandom_range(0, 255); s.b = $urandom_range(0, 255); s.v = 1; s.l = (k == n - 1);
                q.push_back(s);
                sum += longint'((s.a > 127) ? s.a - 256 : s.a) * longint'((s.b > 127) ? s.b - 256 : s.b);
            end
            for (int k = 0; k <= q.size(); k++) begin
                @(negedge clk);
                if (k > 0) begin
                    n_checks++;
                    if ({pe.a_out, pe.a_vld_out, pe.b_out, pe.b_vld_out, pe.last_out} !==
                        {DW'(prev.a), prev.v, DW'(prev.b), prev.v, prev.l}) begin
                        n_errors++;
                        $display("FAIL rand_forward: got a=%0h av=%0b b=%0h bv=%0b l=%0b expected a=%0h b=%0h v=%0b l=%0b",
                                 pe.a_out, pe.a_vld_out, pe.b_out, pe.b_vld_out, pe.last_out,
                                 DW'(prev.a), DW'(prev.b), prev.v, prev.l);
                    end
                end
                if (k < q.size()) begin
                    prev = q[k];
                    pe.a_in = DW'(prev.a); pe.b_in = DW'(prev.b);
                    pe.a_vld_in = prev.v; pe.b_vld_in = prev.v; pe.last_in = prev.l;
                end else begin
                    pe.a_vld_in = 0; pe.b_vld_in = 0; pe.last_in = 0;
                end
            end
            drain_n(0, 1);
            n_checks++;
            if (got_c[0] !== AW'(sum) || got_v[0] !== 1'b1) begin
                n_errors++;
                $display("FAIL rand_tile%0d: got %0d vld %0b expected %0d vld 1", t, got_c[0], got_v[0], AW'(sum));
            end
        end
        n_checks++;
        if (pe.err !== 1'b0) begin n_errors++; $display("FAIL rand_err: got %0b expected 0", pe.err); end
    endtask

    task automatic test_column();
        int exp_col[3] = '{30, 20, 10};
        @(negedge clk);
        cp0.a_in = 8'd2; cp0.b_in = 8'd5; cp0.a_vld_in = 1; cp0.b_vld_in = 1; cp0.last_in = 1;
        cp1.a_in = 8'd4; cp1.b_in = 8'd5; cp1.a_vld_in = 1; cp1.b_vld_in = 1; cp1.last_in = 1;
        cp2.a_in = 8'd5; cp2.b_in = 8'd6; cp2.a_vld_in = 1; cp2.b_vld_in = 1; cp2.last_in = 1;
        @(negedge clk);
        col_idle();
        drain_n(1, 3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got_c[i] !== AW'(exp_col[i]) || got_v[i] !== 1'b1) begin
                n_errors++;
                $display("FAIL column_drain%0d: got %0d vld %0b expected %0d vld 1", i, got_c[i], got_v[i], exp_col[i]);
            end
        end
    endtask

    task automatic test_protocol_err();
        drive(9, 7, 1, 0, 0);
        idle();
        n_checks++;
        if (pe.err !== 1'b1) begin n_errors++; $display("FAIL perr_flag: got %0b expected 1", pe.err); end
        n_checks++;
        if (pe.a_out !== 8'd9 || pe.a_vld_out !== 1'b1 || pe.b_vld_out !== 1'b0 || pe.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL perr_forward: got a=%0d av=%0b bv=%0b busy=%0b expected a=9 av=1 bv=0 busy=0",
                     pe.a_out, pe.a_vld_out, pe.b_vld_out, pe.busy);
        end
        drive(1, 1, 1, 1, 1);
        idle();
        drain_n(0, 1);
        n_checks++;
        if (got_c[0] !== AW'(1)) begin n_errors++; $display("FAIL perr_no_accum: got %0d expected 1", got_c[0]); end
    endtask

    task automatic test_reset_midtile();
        drive(5, 5, 1, 1, 0);
        drive(6, 6, 1, 1, 0);
        @(negedge clk);
        n_checks++;
        if (pe.busy !== 1'b1) begin n_errors++; $display("FAIL rstmid_busy: got %0b expected 1", pe.busy); end
        rst = 1'b1;
        pe.a_vld_in = 0; pe.b_vld_in = 0; pe.last_in = 0;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({pe.a_out, pe.b_out, pe.a_vld_out, pe.b_vld_out, pe.last_out, pe.c_out, pe.c_vld_out,
             pe.busy, pe.err} !== '0) begin
            n_errors++;
            $display("FAIL rstmid_outputs: got a=%0h c=%0h busy=%0b err=%0b expected all 0",
                     pe.a_out, pe.c_out, pe.busy, pe.err);
        end
        drive(2, 2, 1, 1, 1);
        idle();
        drain_n(0, 1);
        n_checks++;
        if (got_c[0] !== AW'(4)) begin n_errors++; $display("FAIL rstmid_result: got %0d expected 4", got_c[0]); end
    endtask

    task automatic test_overwrite();
        drive(1, 2, 1, 1, 1);
        idle();
        idle();
        n_checks++;
        if (pe.err !== 1'b0) begin n_errors++; $display("FAIL ovw_pre_err: got %0b expected 0", pe.err); end
        drive(3, 3, 1, 1, 1);
        idle();
        drain_n(0, 1);
        n_checks++;
        if (pe.err !== 1'b1) begin n_errors++; $display("FAIL ovw_err: got %0b expected 1", pe.err); end
        n_checks++;
        if (got_c[0] !== AW'(9)) begin n_errors++; $display("FAIL ovw_result: got %0d expected 9", got_c[0]); end
    endtask

    task automatic test_saturate();
        logic [AW-1:0] exp_res;
`ifdef SYSTOLIC_PE_SAT_EN
        exp_res = AW'((1 << (AW - 1)) - 1);
`else
        exp_res = AW'(40 * 127 * 127);
`endif
        for (int i = 0; i < 40; i++) drive(127, 127, 1, 1, i == 39);
        idle();
        drain_n(0, 1);
        n_checks++;
        if (got_c[0] !== exp_res) begin
            n_errors++; $display("FAIL sat_result: got %0d expected %0d", got_c[0], exp_res);
        end
`ifdef SYSTOLIC_PE_SAT_EN
        n_checks++;
        if (pe.sat !== 1'b1) begin n_errors++; $display("FAIL sat_flag: got %0b expected 1", pe.sat); end
`endif
    endtask

    initial begin
        rst = 1'b1; col_drain = 1'b0;
        pe.a_in = '0; pe.b_in = '0; pe.a_vld_in = 0; pe.b_vld_in = 0; pe.last_in = 0;
        pe.drain = 0; pe.c_in = '0; pe.c_vld_in = 0;
        cp0.a_in = '0; cp0.b_in = '0; cp1.a_in = '0; cp1.b_in = '0; cp2.a_in = '0; cp2.b_in = '0;
        cp0.c_in = '0; cp0.c_vld_in = 0;
        col_idle();

        test_reset();
        test_basic();
        test_back_to_back();
        test_random();
        test_column();
        test_protocol_err();
        test_reset_midtile();
        test_overwrite();
        test_saturate();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
